// File: rtl/comparador_branch.sv
// Branch comparator: registered taken/flag result behind a one-entry valid/ready output stage.
// Optional taken-statistics counter is built when COMPARADOR_STATS_EN is defined.
`timescale 1ns/1ps
module comparador_branch #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic             igual,
   output logic             menor,
   output logic             menor_u
`ifdef COMPARADOR_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_taken
`endif
);

   if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("comparador_branch: WIDTH out of range 8..64");
   end
   if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
      $error("comparador_branch: CNT_W out of range 4..32");
   end

   function automatic logic sel_taken(input logic [2:0] m,
                                      input logic       eq,
                                      input logic       lt,
                                      input logic       ltu,
                                      input logic       le0);
      logic t;
      t = 1'b0;
      case (m)
         3'b000:  t = eq;
         3'b001:  t = !eq;
         3'b010:  t = lt;
         3'b011:  t = !lt;
         3'b100:  t = ltu;
         3'b101:  t = !ltu;
         3'b110:  t = le0;
         default: t = !le0;
      endcase
      return t;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic signed [WIDTH-1:0] a_s_p0;
   logic signed [WIDTH-1:0] b_s_p0;
   logic                    igual_p0;
   logic                    menor_p0;
   logic                    menor_u_p0;
   logic                    le0_p0;
   logic                    taken_p0;
   logic                    acc_p0;

   logic                    vld_p1;
   logic                    taken_p1;
   logic                    igual_p1;
   logic                    menor_p1;
   logic                    menor_u_p1;
   logic                    xfer_p1;

   // Stage p0: combinational compare of the presented operands
   always_comb begin
      a_s_p0     = $signed(A);
      b_s_p0     = $signed(B);
      igual_p0   = (A == B);
      menor_p0   = (a_s_p0 < b_s_p0);
      menor_u_p0 = (A < B);
      le0_p0     = A[WIDTH-1] || (A == '0);
      taken_p0   = sel_taken(mode, igual_p0, menor_p0, menor_u_p0, le0_p0);
   end

   assign in_ready = (!vld_p1 || out_ready) && !flush;
   assign acc_p0   = in_valid && in_ready;
   // A squashed result never counts as delivered, even if out_ready was high.
   assign xfer_p1  = vld_p1 && out_ready && !flush;

   // Stage p1: result register, loaded only on an accepted input
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1     <= 1'b0;
         taken_p1   <= 1'b0;
         igual_p1   <= 1'b0;
         menor_p1   <= 1'b0;
         menor_u_p1 <= 1'b0;
      end else begin
         if (flush)        vld_p1 <= 1'b0;
         else if (acc_p0)  vld_p1 <= 1'b1;
         else if (xfer_p1) vld_p1 <= 1'b0;

         if (acc_p0) begin
            taken_p1   <= taken_p0;
            igual_p1   <= igual_p0;
            menor_p1   <= menor_p0;
            menor_u_p1 <= menor_u_p0;
         end
      end
   end

   assign out_valid = vld_p1;
   assign taken     = taken_p1;
   assign igual     = igual_p1;
   assign menor     = menor_p1;
   assign menor_u   = menor_u_p1;

`ifdef COMPARADOR_STATS_EN
   logic [CNT_W-1:0] stat_p2;

   // Stage p2: saturating count of delivered taken results; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_p2 <= '0;
      end else if (stat_clr) begin
         stat_p2 <= '0;
      end else if (xfer_p1 && taken_p1) begin
         stat_p2 <= sat_inc(stat_p2);
      end
   end

   assign stat_taken = stat_p2;
`endif

endmodule

// File: tb/tb_comparador_branch.sv
// Self-checking bench for comparador_branch: directed compare vectors, handshake scenarios,
// reset, flush, randomized traffic against a reference model, and the optional statistics counter.
`timescale 1ns/1ps
module tb_comparador_branch;
   localparam int WIDTH = 32;
`ifdef COMPARADOR_STATS_EN
   localparam int CNT_W = 4;
`else
   localparam int CNT_W = 16;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic [2:0]       mode = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             taken;
   logic             igual;
   logic             menor;
   logic             menor_u;
`ifdef COMPARADOR_STATS_EN
   logic             stat_clr = 1'b0;
   logic [CNT_W-1:0] stat_taken;
`endif

   int n_cmp = 0;
   int n_err = 0;

   comparador_branch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .mode      (mode),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .taken     (taken),
      .igual     (igual),
      .menor     (menor),
      .menor_u   (menor_u)
`ifdef COMPARADOR_STATS_EN
     ,.stat_clr  (stat_clr),
      .stat_taken(stat_taken)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: {taken, igual, menor, menor_u} from plain integer arithmetic
   function automatic logic [3:0] ref_flags(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [2:0]       m);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic            t;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      case (m)
         3'd0:    t = (sa == sb);
         3'd1:    t = (sa != sb);
         3'd2:    t = (sa < sb);
         3'd3:    t = (sa >= sb);
         3'd4:    t = (ua < ub);
         3'd5:    t = (ua >= ub);
         3'd6:    t = (sa <= 0);
         default: t = (sa > 0);
      endcase
      return {t, (ua == ub), (sa < sb), (ua < ub)};
   endfunction

   function automatic logic [WIDTH-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [4:0] obs;
      #3;
      obs = {out_valid, taken, igual, menor, menor_u};
      n_cmp++;
      if (obs !== 5'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b required 00000", obs);
      end
`ifdef COMPARADOR_STATS_EN
      n_cmp++;
      if (stat_taken !== '0) begin
         n_err++;
         $display("FAIL reset_stat: got %0d required 0", stat_taken);
      end
`endif
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic test_directed();
      logic [2:0]       v_mode [9];
      logic [WIDTH-1:0] v_a    [9];
      logic [WIDTH-1:0] v_b    [9];
      logic [4:0]       v_exp  [9];
      logic [4:0]       obs;
      v_mode = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b111, 3'b011, 3'b101, 3'b001};
      v_a    = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h5,
                 32'h80000000, 32'h80000000, 32'h1};
      v_b    = '{32'hDEADBEEF, 32'h1, 32'h1, 32'h12345678, 32'h0, 32'h5,
                 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h2};
      v_exp  = '{5'b11100, 5'b11010, 5'b10010, 5'b11011, 5'b10010, 5'b11100,
                 5'b10010, 5'b11010, 5'b11011};
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         mode = v_mode[i];
         A = v_a[i];
         B = v_b[i];
         cyc();
         obs = {out_valid, taken, igual, menor, menor_u};
         n_cmp++;
         if (obs !== v_exp[i]) begin
            n_err++;
            $display("FAIL directed_%0d mode=%b A=%h B=%h: got %b required %b",
                     i, v_mode[i], v_a[i], v_b[i], obs, v_exp[i]);
         end
      end
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL directed_drain: out_valid got %b required 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [4:0] hold;
      logic [4:0] obs;
      logic [4:0] exp;
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 3'b000;
      A = 32'h0000_1234;
      B = 32'h0000_1234;
      hold = 5'b11100;
      cyc();
      obs = {out_valid, taken, igual, menor, menor_u};
      n_cmp++;
      if (obs !== hold) begin
         n_err++;
         $display("FAIL bp_load: got %b required %b", obs, hold);
      end
      for (int i = 0; i < 3; i++) begin
         A = $urandom;
         B = $urandom;
         mode = 3'($urandom);
         #1;
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready_%0d: got %b required 0", i, in_ready);
         end
         cyc();
         obs = {out_valid, taken, igual, menor, menor_u};
         n_cmp++;
         if (obs !== hold) begin
            n_err++;
            $display("FAIL bp_hold_%0d: got %b required %b", i, obs, hold);
         end
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         A = pick_operand();
         B = (i == 1) ? A : pick_operand();
         mode = 3'($urandom);
         exp = {1'b1, ref_flags(A, B, mode)};
         #1;
         n_cmp++;
         if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_in_ready_%0d: got %b required 1", i, in_ready);
         end
         cyc();
         obs = {out_valid, taken, igual, menor, menor_u};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL b2b_result_%0d: got %b required %b", i, obs, exp);
         end
      end
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_drain: out_valid got %b required 0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 3'b000;
      A = 32'd3;
      B = 32'd3;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL flush_load: out_valid got %b required 1", out_valid);
      end
      flush = 1'b1;
      out_ready = 1'b1;
      A = 32'd1;
      B = 32'd2;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_in_ready: got %b required 0", in_ready);
      end
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_clear: out_valid got %b required 0", out_valid);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_not_accepted: out_valid got %b required 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] obs;
      logic [4:0] exp;
      out_ready = 1'b0;
      in_valid = 1'b1;
      mode = 3'b000;
      A = 32'h55;
      B = 32'h55;
      cyc();
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_load: out_valid got %b required 1", out_valid);
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      obs = {out_valid, taken, igual, menor, menor_u};
      n_cmp++;
      if (obs !== 5'b0) begin
         n_err++;
         $display("FAIL rstmid_async: got %b required 00000", obs);
      end
      cyc();
      rst_n = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      mode = 3'b111;
      A = 32'd5;
      B = 32'd0;
      exp = {1'b1, ref_flags(A, B, mode)};
      cyc();
      obs = {out_valid, taken, igual, menor, menor_u};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL rstmid_first_accept: got %b required %b", obs, exp);
      end
      in_valid = 1'b0;
      cyc();
   endtask

   task automatic test_random();
      logic       m_vld;
      logic [3:0] m_flags;
      logic       exp_rdy;
      logic       acc;
      logic       oxf;
      int         m_stat;
      int         stat_max;
      m_vld = 1'b0;
      m_flags = '0;
      m_stat = 0;
      stat_max = (1 << CNT_W) - 1;
`ifdef COMPARADOR_STATS_EN
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
`endif
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         mode      = 3'($urandom);
         A         = pick_operand();
         B         = ($urandom_range(0, 3) == 0) ? A : pick_operand();
`ifdef COMPARADOR_STATS_EN
         stat_clr  = ($urandom_range(0, 31) == 0);
`endif
         #1;
         exp_rdy = (!m_vld || out_ready) && !flush;
         n_cmp++;
         if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL rand_in_ready_%0d: got %b required %b", i, in_ready, exp_rdy);
         end
         acc = in_valid && exp_rdy;
         oxf = m_vld && out_ready && !flush;
`ifdef COMPARADOR_STATS_EN
         if (stat_clr) m_stat = 0;
         else if (oxf && m_flags[3] && m_stat < stat_max) m_stat++;
`endif
         if (flush) m_vld = 1'b0;
         else if (acc) begin
            m_vld = 1'b1;
            m_flags = ref_flags(A, B, mode);
         end else if (oxf) m_vld = 1'b0;
         cyc();
         n_cmp++;
         if (out_valid !== m_vld) begin
            n_err++;
            $display("FAIL rand_out_valid_%0d: got %b required %b", i, out_valid, m_vld);
         end
         if (m_vld) begin
            n_cmp++;
            if ({taken, igual, menor, menor_u} !== m_flags) begin
               n_err++;
               $display("FAIL rand_flags_%0d: got %b required %b", i,
                        {taken, igual, menor, menor_u}, m_flags);
            end
         end
`ifdef COMPARADOR_STATS_EN
         n_cmp++;
         if (int'(stat_taken) !== m_stat) begin
            n_err++;
            $display("FAIL rand_stat_%0d: got %0d required %0d", i, stat_taken, m_stat);
         end
`endif
      end
      in_valid = 1'b0;
      flush = 1'b1;
`ifdef COMPARADOR_STATS_EN
      stat_clr = 1'b0;
`endif
      cyc();
      flush = 1'b0;
   endtask

`ifdef COMPARADOR_STATS_EN
   task automatic test_stats();
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      n_cmp++;
      if (stat_taken !== '0) begin
         n_err++;
         $display("FAIL stat_clear_initial: got %0d required 0", stat_taken);
      end
      out_ready = 1'b1;
      mode = 3'b000;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1;
         A = $urandom;
         B = A;
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (stat_taken !== 4'd15) begin
         n_err++;
         $display("FAIL stat_saturate: got %0d required 15", stat_taken);
      end
      // taken result held, then clear coincides with its transfer
      out_ready = 1'b0;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      out_ready = 1'b1;
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      n_cmp++;
      if (stat_taken !== '0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stat_clr_wins: got stat=%0d vld=%b required stat=0 vld=0",
                  stat_taken, out_valid);
      end
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (stat_taken !== 4'd1) begin
         n_err++;
         $display("FAIL stat_single_inc: got %0d required 1", stat_taken);
      end
      mode = 3'b001;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      cyc();
      n_cmp++;
      if (stat_taken !== 4'd1) begin
         n_err++;
         $display("FAIL stat_not_taken: got %0d required 1", stat_taken);
      end
      mode = 3'b000;
      out_ready = 1'b0;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      flush = 1'b1;
      out_ready = 1'b1;
      cyc();
      flush = 1'b0;
      cyc();
      n_cmp++;
      if (stat_taken !== 4'd1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL stat_flushed: got stat=%0d vld=%b required stat=1 vld=0",
                  stat_taken, out_valid);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
`ifdef COMPARADOR_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/comparador_branch.md
COMPARADOR_BRANCH -- requirements
Module: comparador_branch

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits (legal 8..64).
REQ-002 Parameter: CNT_W, 16, width of taken-statistics counter (legal 4..32).
REQ-003 Port: clk  input  1  rising-edge clock; single clock domain.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  operands and mode valid this cycle.
REQ-006 Port: in_ready  output  1  block accepts input this cycle.
REQ-007 Port: A, B  input  WIDTH each  operands (B ignored for zero-compare modes).
REQ-008 Port: mode  input  3  compare mode per REQ-012.
REQ-009 Port: flush  input  1  discard held result (pipeline squash).
REQ-010 Port: out_valid  output  1; out_ready  input  1; taken  output  1; igual  output  1 (A==B); menor  output  1 (signed A<B); menor_u  output  1 (unsigned A<B).
REQ-011 Port (STATS only): stat_clr  input  1; stat_taken  output  CNT_W  count of accepted results with taken=1.

Function
REQ-012 mode SHALL select taken: 000 A==B; 001 A!=B; 010 A<B signed; 011 A>=B signed; 100 A<B unsigned; 101 A>=B unsigned; 110 A<=0 signed; 111 A>0 signed.
REQ-013 Signed compares SHALL use two's complement at full WIDTH; WIDTH-1 is sign bit; no truncation or extension.
REQ-014 Input transfer SHALL occur when in_valid && in_ready; latency from transfer to out_valid=1 SHALL be exactly 1 cycle.
REQ-015 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-016 Output transfer SHALL occur when out_valid && out_ready; on transfer with no new input, out_valid SHALL fall next cycle.
REQ-017 Simultaneous output transfer and input transfer SHALL load the new result with out_valid held 1 (back-to-back, one result per cycle).
REQ-018 While out_valid && !out_ready, taken/igual/menor/menor_u SHALL hold stable; A, B, mode changes SHALL NOT affect them.
REQ-019 flush=1 SHALL clear out_valid next edge and block input that cycle; flush overrides any simultaneous transfer.
REQ-020 Flags igual/menor/menor_u SHALL be registered together with taken, computed from the same accepted operands.
REQ-021 Output values while out_valid=0 are don't-care but SHALL be registered (no combinational path from A/B to outputs).

Reset
REQ-022 rst_n=0 SHALL immediately force out_valid=0, taken=0, igual=0, menor=0, menor_u=0, stat_taken=0, independent of clk.
REQ-023 Reset mid-transaction SHALL discard any held result; first input after rst_n rises SHALL be accepted on the first clk edge with in_valid=1.
REQ-024 rst_n deassertion SHALL be usable synchronously to clk; no output SHALL glitch high on release.

Configuration
REQ-025 Macro COMPARADOR_STATS_EN SHALL gate statistics logic.
REQ-026 Defined: stat_clr and stat_taken exist; stat_taken SHALL increment by 1 on each output transfer with taken=1, saturate at 2^CNT_W-1, clear to 0 on stat_clr=1 (clear wins over increment in same cycle); flushed results SHALL NOT count.
REQ-027 Not defined: stat_clr and stat_taken ports and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 WIDTH=32, mode=000, A=B=0xDEADBEEF, out_ready=1 -> next cycle out_valid=1, taken=1, igual=1, menor=0, menor_u=0.
REQ-029 mode=010 A=0xFFFFFFFF B=0x00000001 -> taken=1, menor=1, menor_u=0; mode=100 same operands -> taken=0, menor_u=0.
REQ-030 mode=110 A=0 -> taken=1; mode=111 A=0x80000000 -> taken=0; mode=111 A=5 -> taken=1.
REQ-031 Backpressure: result held with out_ready=0 for 3 cycles while A/B toggle -> outputs constant, in_ready=0; out_ready=1 with new in_valid -> back-to-back results, no loss or duplicate.
REQ-032 flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted; rst_n pulse mid-hold -> out_valid=0 immediately, before next clk edge.
REQ-033 COMPARADOR_STATS_EN, CNT_W=4: 20 taken transfers -> stat_taken=15 (saturated); stat_clr with concurrent taken transfer -> 0; flushed taken result -> no increment.
